conv2d_stream_engine: RTL

- Streaming multi-channel 2D convolution engine: the next-generation conv stage of the CNN datapath.
- Accepts one pixel per cycle (all channels packed) over a valid/ready handshake and buffers KERNEL-1 image rows internally.
- Emits one biased, optionally ReLU'd, 32-bit feature per strided window position over a valid/ready handshake, with a last flag.
- Weights are loaded through a write port while idle.

---
 rtl/cnn_pkg.sv | 26 ++
 rtl/conv_line_buffer.sv | 74 +++++++
 rtl/conv2d_stream_engine.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/cnn_pkg.sv
// Shared constants, FSM encoding and elaboration-time helpers for the CNN datapath.
package cnn_pkg;

  localparam int PIX_DATA_W = 8;
  localparam int ACC_DATA_W = 32;
  localparam int BIAS_W     = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Never returns less than 1 so it can size a vector directly.
  function automatic int clog2(input int value);
    int r;
    for (r = 0; (32'sd1 << r) < value; r++) begin
    end
    return (r < 1) ? 1 : r;
  endfunction

  function automatic int out_dim(input int img, input int k, input int s);
    return (img - k) / s + 1;
  endfunction

endpackage

// File: rtl/conv_line_buffer.sv
// KERNEL-1 circular row buffers feeding a KERNEL x KERNEL shift window.
module conv_line_buffer
  import cnn_pkg::*;
#(
  parameter int IMG_WIDTH = 64,
  parameter int KERNEL    = 3,
  parameter int PIX_W     = 8,
  parameter int COL_W     = clog2(IMG_WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic [COL_W-1:0] col,
  input  logic [PIX_W-1:0] pixel,
  output logic [PIX_W-1:0] win [KERNEL][KERNEL]
);

  localparam int ROWS   = KERNEL - 1;
  localparam int SLOT_W = clog2(ROWS);

  logic [PIX_W-1:0]  rows_r    [ROWS][IMG_WIDTH];
  logic [PIX_W-1:0]  column_s  [KERNEL];
  logic [SLOT_W-1:0] rd_slot_s [ROWS];
  logic [SLOT_W-1:0] slot_r;

  // Slot slot_r holds the oldest buffered row; rows age upward modulo ROWS.
  always_comb begin
    int rs;
    rs = 0;
    for (int i = 0; i < ROWS; i++) begin
      rs = int'(slot_r) + i;
      if (rs >= ROWS) begin
        rs = rs - ROWS;
      end else begin
        rs = rs;
      end
      rd_slot_s[i] = SLOT_W'(rs);
      column_s[i]  = rows_r[rd_slot_s[i]][col];
    end
    column_s[KERNEL-1] = pixel;
  end

  // Row storage: the incoming pixel replaces the oldest row's entry at this column.
  always_ff @(posedge clk) begin
    if (en) begin
      rows_r[slot_r][col] <= pixel;
    end
  end

  // Window shifts left by one column per accepted pixel.
  always_ff @(posedge clk) begin
    if (en) begin
      for (int ky = 0; ky < KERNEL; ky++) begin
        for (int kx = 0; kx < KERNEL - 1; kx++) begin
          win[ky][kx] <= win[ky][kx+1];
        end
        win[ky][KERNEL-1] <= column_s[ky];
      end
    end
  end

  // Oldest-row pointer advances at the end of every image row.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      slot_r <= '0;
    end else if (clr) begin
      slot_r <= '0;
    end else if (en && (col == COL_W'(IMG_WIDTH - 1))) begin
      slot_r <= (slot_r == SLOT_W'(ROWS - 1)) ? '0 : slot_r + SLOT_W'(1);
    end
  end

endmodule

// File: rtl/conv2d_stream_engine.sv
// Streaming multi-channel 2D convolution: line-buffered window, MAC stage, bias/ReLU stage.
module conv2d_stream_engine
  import cnn_pkg::*;
#(
  parameter int IMG_HEIGHT = 64,
  parameter int IMG_WIDTH  = 64,
  parameter int KERNEL     = 3,
  parameter int CHANNELS   = 1,
  parameter int STRIDE     = 1,
  parameter int DATA_W     = PIX_DATA_W,
  parameter int ACC_W      = ACC_DATA_W
) (
  input  logic                                       clk,
  input  logic                                       rst,
  input  logic                                       start,
  input  logic                                       relu_en,
  input  logic [BIAS_W-1:0]                          bias,
  input  logic                                       w_valid,
  input  logic [clog2(KERNEL*KERNEL*CHANNELS)-1:0]   w_addr,
  input  logic [DATA_W-1:0]                          w_data,
  input  logic                                       in_valid,
  output logic                                       in_ready,
  input  logic [CHANNELS*DATA_W-1:0]                 in_pixel,
  output logic                                       out_valid,
  input  logic                                       out_ready,
  output logic [ACC_W-1:0]                           out_data,
  output logic                                       out_last,
  output logic                                       busy,
  output logic                                       done
);

  localparam int NW       = KERNEL * KERNEL * CHANNELS;
  localparam int AW       = clog2(NW);
  localparam int PIX_W    = CHANNELS * DATA_W;
  localparam int ROW_W    = clog2(IMG_HEIGHT);
  localparam int COL_W    = clog2(IMG_WIDTH);
  localparam int CNT_W    = clog2(IMG_HEIGHT * IMG_WIDTH + 1);
  localparam int PH_W     = clog2(STRIDE);
  localparam int PROD_W   = 2 * DATA_W + 1;
  localparam int OUT_H    = out_dim(IMG_HEIGHT, KERNEL, STRIDE);
  localparam int OUT_W    = out_dim(IMG_WIDTH, KERNEL, STRIDE);
  localparam int LAST_ROW = (OUT_H - 1) * STRIDE + KERNEL - 1;
  localparam int LAST_COL = (OUT_W - 1) * STRIDE + KERNEL - 1;

  state_t state_r, state_nxt;

  logic [ROW_W-1:0]         row_r;
  logic [COL_W-1:0]         col_r;
  logic [PH_W-1:0]          row_ph_r, col_ph_r;
  logic [CNT_W-1:0]         pix_cnt_r;
  logic signed [BIAS_W-1:0] bias_r;
  logic                     relu_r;
  logic signed [DATA_W-1:0] w_mem [NW];
  logic [PIX_W-1:0]         win_s [KERNEL][KERNEL];

  logic                     win_vld_r, win_last_r;
  logic                     s1_vld_r, s1_last_r;
  logic signed [ACC_W-1:0]  s1_sum_r;
  logic                     out_valid_r, out_last_r;
  logic [ACC_W-1:0]         out_data_r;
  logic                     busy_r, done_r;

  logic                     frame_start_s, stall_s, accept_s, complete_s, is_last_s, we_s;
  logic [DATA_W-1:0]        px_s;
  logic signed [PROD_W-1:0] prod_s;
  logic signed [ACC_W-1:0]  sum_s, biased_s, result_s;

  assign frame_start_s = (state_r == ST_IDLE) && start;
  assign stall_s       = out_valid_r && !out_ready;
  assign in_ready      = (state_r == ST_RUN) && (pix_cnt_r < CNT_W'(IMG_HEIGHT * IMG_WIDTH)) && !stall_s;
  assign accept_s      = in_valid && in_ready;
  assign complete_s    = (row_r >= ROW_W'(KERNEL - 1)) && (col_r >= COL_W'(KERNEL - 1)) &&
                         (row_ph_r == '0) && (col_ph_r == '0);
  assign is_last_s     = (row_r == ROW_W'(LAST_ROW)) && (col_r == COL_W'(LAST_COL));
  assign we_s          = w_valid && (state_r != ST_RUN) && ({1'b0, w_addr} < (AW+1)'(NW));

  assign out_valid = out_valid_r;
  assign out_data  = out_data_r;
  assign out_last  = out_last_r;
  assign busy      = busy_r;
  assign done      = done_r;

  // State register plus registered status flags derived from the next state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= ST_IDLE;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_nxt;
      busy_r  <= (state_nxt == ST_RUN);
      done_r  <= (state_nxt == ST_DONE);
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state_r;
    case (state_r)
      ST_IDLE: state_nxt = start ? ST_RUN : ST_IDLE;
      ST_RUN:  state_nxt = (out_valid_r && out_ready && out_last_r) ? ST_DONE : ST_RUN;
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Weight RAM keeps its contents across reset.
  always_ff @(posedge clk) begin
    if (we_s) begin
      w_mem[w_addr] <= $signed(w_data);
    end
  end

  // Frame configuration captured at start.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bias_r <= '0;
      relu_r <= 1'b0;
    end else if (frame_start_s) begin
      bias_r <= $signed(bias);
      relu_r <= relu_en;
    end
  end

  // Raster position and stride phase; a phase of zero marks a window-aligned row/column.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      row_r     <= '0;
      col_r     <= '0;
      row_ph_r  <= '0;
      col_ph_r  <= '0;
      pix_cnt_r <= '0;
    end else if (frame_start_s) begin
      row_r     <= '0;
      col_r     <= '0;
      row_ph_r  <= '0;
      col_ph_r  <= '0;
      pix_cnt_r <= '0;
    end else if (accept_s) begin
      pix_cnt_r <= pix_cnt_r + CNT_W'(1);
      if (col_r == COL_W'(IMG_WIDTH - 1)) begin
        col_r    <= '0;
        col_ph_r <= '0;
        row_r    <= row_r + ROW_W'(1);
        if (row_r >= ROW_W'(KERNEL - 1)) begin
          row_ph_r <= (row_ph_r == PH_W'(STRIDE - 1)) ? '0 : row_ph_r + PH_W'(1);
        end
      end else begin
        col_r <= col_r + COL_W'(1);
        if (col_r >= COL_W'(KERNEL - 1)) begin
          col_ph_r <= (col_ph_r == PH_W'(STRIDE - 1)) ? '0 : col_ph_r + PH_W'(1);
        end
      end
    end
  end

  conv_line_buffer #(
    .IMG_WIDTH (IMG_WIDTH),
    .KERNEL    (KERNEL),
    .PIX_W     (PIX_W),
    .COL_W     (COL_W)
  ) u_line_buffer (
    .clk   (clk),
    .rst   (rst),
    .clr   (frame_start_s),
    .en    (accept_s),
    .col   (col_r),
    .pixel (in_pixel),
    .win   (win_s)
  );

  // Multiply-accumulate over the window; pixels are unsigned, weights signed.
  always_comb begin
    sum_s  = '0;
    px_s   = '0;
    prod_s = '0;
    for (int ky = 0; ky < KERNEL; ky++) begin
      for (int kx = 0; kx < KERNEL; kx++) begin
        for (int c = 0; c < CHANNELS; c++) begin
          px_s   = win_s[ky][kx][c*DATA_W +: DATA_W];
          prod_s = PROD_W'($signed({1'b0, px_s})) * PROD_W'(w_mem[(ky*KERNEL+kx)*CHANNELS+c]);
          sum_s  = sum_s + ACC_W'(prod_s);
        end
      end
    end
  end

  // Bias and optional ReLU.
  always_comb begin
    biased_s = s1_sum_r + ACC_W'(bias_r);
    if (relu_r && biased_s[ACC_W-1]) begin
      result_s = '0;
    end else begin
      result_s = biased_s;
    end
  end

  // Three-slot pipeline (window, sum, output) that freezes as a whole while the output stalls.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      win_vld_r   <= 1'b0;
      win_last_r  <= 1'b0;
      s1_vld_r    <= 1'b0;
      s1_last_r   <= 1'b0;
      s1_sum_r    <= '0;
      out_valid_r <= 1'b0;
      out_last_r  <= 1'b0;
      out_data_r  <= '0;
    end else if (!stall_s) begin
      win_vld_r   <= accept_s && complete_s;
      win_last_r  <= accept_s && complete_s && is_last_s;
      s1_vld_r    <= win_vld_r;
      s1_last_r   <= win_last_r;
      out_valid_r <= s1_vld_r;
      out_last_r  <= s1_last_r;
      if (win_vld_r) begin
        s1_sum_r <= sum_s;
      end
      if (s1_vld_r) begin
        out_data_r <= result_s;
      end
    end
  end

endmodule
